regfile_sequencer: RTL
======================

# regfile_sequencer

Multi-cycle execute/writeback sequencer that drives the 8×8-bit register file. It accepts one 16-bit register-to-register or immediate instruction through a valid/ready handshake. For each instruction it:
- issues the two read addresses and captures the operands,
- computes an 8-bit result,
- writes the result back through the register file's load port, asserting the write strobe for exactly one cycle.

It sits between instruction fetch and the register file and is the only writer of the register file.

## Interface
Parameters: none. Widths are fixed: 8-bit data, 3-bit register addresses, 16-bit instruction.
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high
- instr  in  16  instruction word, sampled when instr_valid & instr_ready
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept an instruction
- rf_sa  out  3  register file read address A
- rf_sb  out  3  register file read address B
- rf_data_a  in  8  register file read data A (combinational from rf_sa)
- rf_data_b  in  8  register file read data B (combinational from rf_sb)
- rf_ld  out  1  register file write strobe
- rf_dr  out  3  register file write address
- rf_din  out  8  register file write data
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  valid with done; 1 = opcode not implemented
- flag_z, flag_n, flag_c  out  1 each  zero, negative and carry flags from the last retired ALU instruction

## Operation
- Instruction fields:
  - [15:12] opcode
  - [11:9] DR
  - [8:6] SA
  - [5:3] SB
  - [5:0] imm6, sign-extended to 8 bits
- Opcodes (all arithmetic modulo 256):
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 ADDI: A+sext(imm6)
  - 6 LI: sext(imm6); operands ignored
  - 7 SLL: A<<B[2:0]
  - 8 SRL: logical A>>B[2:0]
  - 9 SLT: 8'd1 if A<B signed, else 8'd0
  - 10 NOP
  - 11–15 illegal
- FSM states are IDLE, READ, EXEC, WRITE:
  - IDLE: instr_ready=1. On handshake, latch instr into an internal register, drive rf_sa/rf_sb from the SA/SB fields, then go to READ.
  - READ: rf_sa/rf_sb are stable. Capture rf_data_a/rf_data_b into operand registers at the end of the cycle, then go to EXEC.
  - EXEC: compute the result and next flags into registers, then go to WRITE.
  - WRITE (lasts one cycle):
    - Opcodes 0–9: rf_ld=1, rf_dr=DR, rf_din=result; flags update at the end of the cycle.
    - NOP and illegal: rf_ld=0 and flags are unchanged.
    - done=1 for all opcodes; illegal=1 for opcodes 11–15.
    - Next state is IDLE.
- Flags:
  - Z = (result==0).
  - N = result[7].
  - C:
    - ADD/ADDI: carry out of bit 7.
    - SUB: 1 when A≥B unsigned (no borrow).
    - All other ALU opcodes: 0.
- rf_ld, done and illegal are 0 in every state except WRITE.
- rf_sa/rf_sb/rf_dr/rf_din hold their last values when not in use.
- instr_valid outside IDLE is ignored; instr is not sampled.
- Writes to register 0 are permitted; r0 is an ordinary register.

## Timing
- Reset values:
  - state IDLE
  - instr_ready 0 while RESET=1, then 1 from the first cycle after release
  - rf_sa, rf_sb, rf_dr, rf_din all 0
  - rf_ld, done, illegal all 0
  - flags all 0
- Latency is 4 cycles from the handshake edge to retirement:
  - edge 0: accept
  - READ at cycle 1
  - EXEC at cycle 2
  - WRITE at cycle 3, with rf_ld/done high
  - back in IDLE at cycle 4
- Throughput is one instruction per 4 cycles with back-to-back valid.
- A write in instruction k lands at the edge ending WRITE. Instruction k+1 reads at least 2 cycles later, so a RAW on the same register always sees the new value and no bypass is needed.
- RESET asserted in any state:
  - the next state is IDLE;
  - no rf_ld or done is issued for the aborted instruction;
  - the latched instruction is discarded.
- RESET and instr_valid in the same cycle: the instruction is not accepted.

## Test plan
- Reset, then hold instr_valid=0 → all outputs at reset values; instr_ready=1 from the first post-reset cycle; rf_ld never asserts.
- Preload r1=8'h7F, r2=8'h01; ADD r3,r1,r2 → rf_ld for exactly one cycle, 3 cycles after accept, with rf_dr=3, rf_din=8'h80; flags N=1, Z=0, C=0; done high in the same cycle.
- LI r4,−1 (imm6=6'h3F) → rf_din=8'hFF. Then SUB r5,r4,r4 → rf_din=8'h00 with Z=1, C=1.
- RAW chain:
  - back-to-back ADDI r1,r1,1 ×3 starting from r1=8'hFE, instr_valid held high;
  - required: successive rf_din values 8'hFF, 8'h00, 8'h01, and C=1 only after the second instruction;
  - required: instr_ready asserts every 4th cycle.
- Opcode 4'hC → done=1, illegal=1, rf_ld=0, flags unchanged. NOP → done=1, illegal=0, rf_ld=0.
- Assert RESET in the EXEC cycle of an ADD → no rf_ld or done follows; IDLE with instr_ready=1 on the cycle after RESET deasserts; the next SLT with r1=8'h80, r2=8'h01 yields rf_din=8'h01.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Execute/writeback sequencer for the 8x8-bit register file: accepts one 16-bit
// instruction per handshake, reads two operands, computes, and writes back once.
module regfile_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  rf_sa,
  output logic [2:0]  rf_sb,
  input  logic [7:0]  rf_data_a,
  input  logic [7:0]  rf_data_b,
  output logic        rf_ld,
  output logic [2:0]  rf_dr,
  output logic [7:0]  rf_din,
  output logic        done,
  output logic        illegal,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LI   = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'd10;

  state_t      state, next_state;
  logic [15:0] ir;
  logic [7:0]  op_a, op_b;
  logic        nxt_z, nxt_n, nxt_c;

  logic [3:0]  opcode;
  logic [7:0]  imm_ext;
  logic        ir_writes, ir_illegal;
  logic        accept, in_write;
  logic [7:0]  alu_res;
  logic        alu_c;

  assign opcode     = ir[15:12];
  assign imm_ext    = {{2{ir[5]}}, ir[5:0]};
  assign ir_writes  = (opcode <= OP_SLT);
  assign ir_illegal = (opcode > OP_NOP);

  // RESET gates the handshake and the WRITE strobes so an aborted
  // instruction can never retire, even when reset lands in WRITE.
  assign instr_ready = (state == S_IDLE) && !RESET;
  assign accept      = instr_ready && instr_valid;
  assign in_write    = (state == S_WRITE) && !RESET;

  assign rf_ld   = in_write && ir_writes;
  assign done    = in_write;
  assign illegal = in_write && ir_illegal;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_READ;
      S_READ:  next_state = S_EXEC;
      S_EXEC:  next_state = S_WRITE;
      S_WRITE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = 8'd0;
    alu_c   = 1'b0;
    case (opcode)
      OP_ADD:  {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB:  begin
        alu_res = op_a - op_b;
        alu_c   = (op_a >= op_b);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_ADDI: {alu_c, alu_res} = {1'b0, op_a} + {1'b0, imm_ext};
      OP_LI:   alu_res = imm_ext;
      OP_SLL:  alu_res = op_a << op_b[2:0];
      OP_SRL:  alu_res = op_a >> op_b[2:0];
      OP_SLT:  alu_res = {7'd0, ($signed(op_a) < $signed(op_b))};
      default: alu_res = 8'd0;
    endcase
  end

  // Register-file-facing outputs are plain registers: they only move when
  // an instruction needs them and otherwise hold their last value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      rf_sa  <= '0;
      rf_sb  <= '0;
      rf_dr  <= '0;
      rf_din <= '0;
      nxt_z  <= 1'b0;
      nxt_n  <= 1'b0;
      nxt_c  <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      if (accept) begin
        ir    <= instr;
        rf_sa <= instr[8:6];
        rf_sb <= instr[5:3];
      end
      if (state == S_READ) begin
        op_a <= rf_data_a;
        op_b <= rf_data_b;
      end
      if (state == S_EXEC && ir_writes) begin
        rf_dr  <= ir[11:9];
        rf_din <= alu_res;
        nxt_z  <= (alu_res == 8'd0);
        nxt_n  <= alu_res[7];
        nxt_c  <= alu_c;
      end
      if (in_write && ir_writes) begin
        flag_z <= nxt_z;
        flag_n <= nxt_n;
        flag_c <= nxt_c;
      end
    end
  end

endmodule
